// File: rtl/alu_scheduler.sv
// Two-requester ALU front end: round-robin grant, one operation in flight,
// single-cycle ALU ops and an 8-cycle restoring divider, held response.
module alu_scheduler #(
    parameter logic [7:0] DZ_VALUE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [2:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [7:0] resp_result,
    output logic       resp_err,
    input  logic       resp_ready,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DIV, RESP} state_t;

    state_t     state;
    logic       last_grant;
    logic       grant_id;
    logic       accept;
    logic [2:0] sel_op;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] rem;
    logic [6:0] quot;
    logic [2:0] cnt;
    logic [8:0] trial;
    logic [8:0] diff;
    logic       q_bit;

    function automatic logic [7:0] alu_result(input logic [2:0] op,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        case (op)
            3'b000:  alu_result = a + b;
            3'b001:  alu_result = d;
            3'b010:  alu_result = a * b;
            3'b100:  alu_result = (d == 8'h00) ? 8'h00 : (d[7] ? 8'h01 : 8'h02);
            default: alu_result = 8'h00;
        endcase
    endfunction

    function automatic logic is_err(input logic [2:0] op, input logic [7:0] b);
        is_err = (op > 3'd4) || ((op == 3'd3) && (b == 8'h00));
    endfunction

    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else if (req1_valid)
            grant_id = 1'b1;
    end

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign sel_op     = grant_id ? req1_op : req0_op;
    assign sel_a      = grant_id ? req1_a  : req0_a;
    assign sel_b      = grant_id ? req1_b  : req0_b;
    assign busy       = (state != IDLE);

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    assign trial = {rem, dvd[7]};
    assign diff  = trial - {1'b0, dvs};
    assign q_bit = ~diff[8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= 8'h00;
            resp_err    <= 1'b0;
            dvd         <= 8'h00;
            dvs         <= 8'h00;
            rem         <= 8'h00;
            quot        <= 7'h00;
            cnt         <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant_id;
                        resp_id    <= grant_id;
                        if (sel_op == 3'b011 && sel_b != 8'h00) begin
                            state <= DIV;
                            dvd   <= sel_a;
                            dvs   <= sel_b;
                            rem   <= 8'h00;
                            quot  <= 7'h00;
                            cnt   <= 3'd0;
                        end else begin
                            state       <= RESP;
                            resp_valid  <= 1'b1;
                            resp_result <= (sel_op == 3'b011) ? DZ_VALUE
                                                              : alu_result(sel_op, sel_a, sel_b);
                            resp_err    <= is_err(sel_op, sel_b);
                        end
                    end
                end
                DIV: begin
                    rem  <= q_bit ? diff[7:0] : trial[7:0];
                    quot <= {quot[5:0], q_bit};
                    dvd  <= {dvd[6:0], 1'b0};
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state       <= RESP;
                        resp_valid  <= 1'b1;
                        resp_result <= {quot, q_bit};
                        resp_err    <= 1'b0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
